// File: rtl/ccd_pixel_capture.sv
// CCD pixel capture: detects phi_p/phi_r falls, sequences the ADC strobe,
// discards leading dummy pixels and queues active samples in an 8-deep FWFT FIFO.

module ccd_pix_fifo #(
  parameter int W = 26
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop_req,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         drop
);
  logic [W-1:0] mem [8];
  logic [2:0]   wr_ptr, rd_ptr;
  logic [3:0]   count;
  logic         full, pop, wr_ok;

  assign valid = (count != 4'd0);
  assign full  = (count == 4'd8);
  assign pop   = valid && pop_req;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)   rd_ptr <= rd_ptr + 3'd1;
      count <= count + {3'd0, wr_ok} - {3'd0, pop};
    end
  end
endmodule

module ccd_pixel_capture #(
  parameter int DATA_W       = 12,
  parameter int SAMPLE_DELAY = 1,
  parameter int DUMMY_LEAD   = 2,
  parameter int ACTIVE_PIX   = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_phi_p,
  input  logic              i_phi_r,
  output logic              o_adc_conv,
  input  logic              i_adc_done,
  input  logic [DATA_W-1:0] i_adc_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [DATA_W-1:0] o_pix_data,
  output logic [11:0]       o_pix_idx,
  output logic              o_pix_first,
  output logic              o_pix_last,
  output logic              o_overrun,
  output logic              o_overflow,
  output logic              o_short_frame
);
  localparam int ENT_W = DATA_W + 14;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;
  localparam logic [1:0] S_CONV  = 2'd3;
  localparam logic [11:0] LAST_CNT = 12'(DUMMY_LEAD + ACTIVE_PIX - 1);
  localparam logic [11:0] DL       = 12'(DUMMY_LEAD);
  localparam logic [11:0] LAST_IDX = 12'(ACTIVE_PIX - 1);

  logic phi_p_cur, phi_p_prev, phi_r_cur, phi_r_prev;
  logic p_fall, p_rise, r_fall;
  logic [1:0]  state;
  logic [3:0]  dly_cnt;
  logic [11:0] pix_cnt, pix_idx;
  logic        abort, take_done, push_req, fifo_drop, head_vld;
  logic [ENT_W-1:0] push_ent, head;

  // same clock domain as the generator: one sample stage plus a history bit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phi_p_cur  <= 1'b1;
      phi_p_prev <= 1'b1;
      phi_r_cur  <= 1'b1;
      phi_r_prev <= 1'b1;
    end else begin
      phi_p_cur  <= i_phi_p;
      phi_p_prev <= phi_p_cur;
      phi_r_cur  <= i_phi_r;
      phi_r_prev <= phi_r_cur;
    end
  end

  assign p_fall = phi_p_prev && !phi_p_cur;
  assign p_rise = !phi_p_prev && phi_p_cur;
  assign r_fall = phi_r_prev && !phi_r_cur;

  assign abort      = p_rise && (state != S_IDLE);
  assign take_done  = (state == S_CONV) && i_adc_done && !abort;
  assign push_req   = take_done && (pix_cnt >= DL);
  assign o_adc_conv = (state == S_DELAY) && (dly_cnt == 4'd0) && !abort;

  assign pix_idx  = pix_cnt - DL;
  assign push_ent = {i_adc_data, pix_idx, pix_idx == 12'd0, pix_idx == LAST_IDX};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      dly_cnt <= 4'd0;
      pix_cnt <= 12'd0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (p_fall) begin
          pix_cnt <= 12'd0;
          state   <= S_WAIT;
        end
        S_WAIT: if (r_fall) begin
          dly_cnt <= 4'(SAMPLE_DELAY);
          state   <= S_DELAY;
        end
        S_DELAY: begin
          if (dly_cnt == 4'd0) state <= S_CONV;
          else dly_cnt <= dly_cnt - 4'd1;
        end
        default: if (i_adc_done) begin
          pix_cnt <= pix_cnt + 12'd1;
          state   <= (pix_cnt == LAST_CNT) ? S_IDLE : S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_overrun     <= 1'b0;
      o_overflow    <= 1'b0;
      o_short_frame <= 1'b0;
    end else begin
      if (r_fall && (state == S_DELAY || state == S_CONV)) o_overrun <= 1'b1;
      if (fifo_drop) o_overflow <= 1'b1;
      if (abort) o_short_frame <= 1'b1;
    end
  end

  ccd_pix_fifo #(.W(ENT_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push_req),
    .din     (push_ent),
    .pop_req (i_pix_ready),
    .valid   (head_vld),
    .dout    (head),
    .drop    (fifo_drop)
  );

  // head fields read as zero when empty so outputs are defined out of reset
  assign o_pix_valid = head_vld;
  assign {o_pix_data, o_pix_idx, o_pix_first, o_pix_last} = head_vld ? head : '0;
endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Bench for ccd_pixel_capture: table of frame scenarios, random frames and
// hand-written corner sequences against a queue-based scoreboard.

module tb_ccd_pixel_capture;
  localparam int DL = 2;
  localparam int AP = 8;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_phi_p = 1'b1, i_phi_r = 1'b1;
  logic        i_adc_done = 1'b0, i_pix_ready = 1'b0;
  logic [11:0] i_adc_data = 12'd0;
  logic        o_adc_conv, o_pix_valid, o_pix_first, o_pix_last;
  logic        o_overrun, o_overflow, o_short_frame;
  logic [11:0] o_pix_data, o_pix_idx;
  logic        l_conv, l_valid, l_first, l_last, l_ovr, l_ovf, l_short;
  logic [11:0] l_data, l_idx;

  ccd_pixel_capture #(.DATA_W(12), .SAMPLE_DELAY(1), .DUMMY_LEAD(DL), .ACTIVE_PIX(AP)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_phi_p(i_phi_p), .i_phi_r(i_phi_r),
    .o_adc_conv(o_adc_conv), .i_adc_done(i_adc_done), .i_adc_data(i_adc_data),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready), .o_pix_data(o_pix_data),
    .o_pix_idx(o_pix_idx), .o_pix_first(o_pix_first), .o_pix_last(o_pix_last),
    .o_overrun(o_overrun), .o_overflow(o_overflow), .o_short_frame(o_short_frame));

  ccd_pixel_capture #(.DATA_W(12), .SAMPLE_DELAY(3), .DUMMY_LEAD(DL), .ACTIVE_PIX(AP)) u_lat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_phi_p(i_phi_p), .i_phi_r(i_phi_r),
    .o_adc_conv(l_conv), .i_adc_done(i_adc_done), .i_adc_data(i_adc_data),
    .o_pix_valid(l_valid), .i_pix_ready(i_pix_ready), .o_pix_data(l_data),
    .o_pix_idx(l_idx), .o_pix_first(l_first), .o_pix_last(l_last),
    .o_overrun(l_ovr), .o_overflow(l_ovf), .o_short_frame(l_short));

  always #5 i_clk = ~i_clk;

  typedef struct { int data; int idx; bit first; bit last; } ent_t;
  typedef struct {
    string name; int npix; int gap; int lat; int rdy; int dmode;
    int outs; int convs; bit ovr; bit latc;
  } row_t;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 1, data_mode = 0, adc_lat = 1;
  int   adc_cd = 0, frame_pix = 0, pops = 0;
  bit   exp_ovf = 0, phi_p_seen = 1;
  ent_t model[$];
  int   conv_q[$], lat_q[$], fall_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pack(input ent_t e);
    return (e.data << 14) | (e.idx << 2) | (int'(e.first) << 1) | int'(e.last);
  endfunction

  // Consumer, ADC model and scoreboard; runs at the falling edge of each cycle.
  task automatic monitor();
    ent_t e;
    int   d;
    case (rdy_mode)
      0:       i_pix_ready = 1'b1;
      1:       i_pix_ready = 1'b0;
      default: i_pix_ready = 1'($urandom_range(0, 1));
    endcase
    i_adc_done = 1'b0;
    if (!i_rst_n) begin
      model.delete();
      adc_cd = 0; frame_pix = 0; exp_ovf = 0;
    end else begin
      chk("pix_valid", int'(o_pix_valid), int'(model.size() > 0));
      chk("overflow_flag", int'(o_overflow), int'(exp_ovf));
      if (model.size() > 0) begin
        chk("pix_head", int'({o_pix_data, o_pix_idx, o_pix_first, o_pix_last}), pack(model[0]));
        if (i_pix_ready) begin
          void'(model.pop_front());
          pops++;
        end
      end
      if (phi_p_seen && !i_phi_p) frame_pix = 0;
      if (adc_cd > 0) begin
        adc_cd--;
        if (adc_cd == 0) begin
          d = (data_mode == 0) ? frame_pix * 3 : int'($urandom_range(0, 4095));
          i_adc_data = 12'(d);
          i_adc_done = 1'b1;
          if (frame_pix >= DL && frame_pix < DL + AP) begin
            e.data = d; e.idx = frame_pix - DL;
            e.first = (e.idx == 0); e.last = (e.idx == AP - 1);
            if (model.size() < 8) model.push_back(e);
            else exp_ovf = 1;
          end
          frame_pix++;
        end
      end
      if (o_adc_conv) begin
        conv_q.push_back(cyc);
        adc_cd = adc_lat;
      end
      if (l_conv) lat_q.push_back(cyc);
    end
    phi_p_seen = i_phi_p;
  endtask

  task automatic step();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_phi_p = 1'b1; i_phi_r = 1'b1;
    step(); step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic pix_edge(input int gap);
    fall_q.push_back(cyc);
    i_phi_r = 1'b0;
    step();
    i_phi_r = 1'b1;
    repeat (gap - 1) step();
  endtask

  task automatic start_frame();
    i_phi_p = 1'b0;
    repeat (3) step();
  endtask

  task automatic end_frame();
    i_phi_p = 1'b1;
    repeat (3) step();
  endtask

  task automatic pixels(input int n, input int gap);
    for (int k = 0; k < n; k++) pix_edge(gap);
  endtask

  task automatic drain(input bit need_empty);
    int n = 0;
    while ((adc_cd > 0 || (need_empty && model.size() > 0)) && n < 400) begin
      step();
      n++;
    end
    chk("drain_in_time", int'(n < 400), 1);
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[5];
    int c0, p0, l0, t0;
    rows[0] = '{"nominal", 12, 4, 1, 0, 0, 8, 10, 1'b0, 1'b1};
    rows[1] = '{"rand_rdy_g6", 10, 6, 3, 2, 1, 8, 10, 1'b0, 1'b1};
    rows[2] = '{"rand_rdy_g5", 10, 5, 2, 2, 1, 8, 10, 1'b0, 1'b1};
    rows[3] = '{"tight_g4", 10, 4, 1, 2, 1, 8, 10, 1'b0, 1'b1};
    rows[4] = '{"overrun", 40, 4, 10, 0, 0, 8, 10, 1'b1, 1'b0};

    @(posedge i_clk);
    #1;
    do_reset();
    chk("rst_conv", int'(o_adc_conv), 0);
    chk("rst_valid", int'(o_pix_valid), 0);
    chk("rst_data", int'({o_pix_data, o_pix_idx, o_pix_first, o_pix_last}), 0);
    chk("rst_flags", int'({o_overrun, o_overflow, o_short_frame}), 0);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      rdy_mode = rows[r].rdy; data_mode = rows[r].dmode; adc_lat = rows[r].lat;
      fall_q.delete();
      c0 = conv_q.size(); p0 = pops;
      start_frame();
      pixels(rows[r].npix, rows[r].gap);
      drain(1);
      end_frame();
      chk({rows[r].name, "_outs"}, pops - p0, rows[r].outs);
      chk({rows[r].name, "_convs"}, conv_q.size() - c0, rows[r].convs);
      chk({rows[r].name, "_overrun"}, int'(o_overrun), int'(rows[r].ovr));
      chk({rows[r].name, "_short"}, int'(o_short_frame), 0);
      if (rows[r].latc && conv_q.size() - c0 == rows[r].convs)
        for (int k = 0; k < rows[r].convs; k++)
          chk({rows[r].name, "_conv_cycle"}, conv_q[c0 + k], fall_q[k] + 3);
    end

    // random frames with random spacing, ADC latency, ready and data
    do_reset();
    rdy_mode = 2; data_mode = 1;
    for (int f = 0; f < 6; f++) begin
      int gap;
      gap = int'($urandom_range(4, 8));
      adc_lat = int'($urandom_range(1, gap - 3));
      fall_q.delete();
      c0 = conv_q.size(); p0 = pops;
      start_frame();
      pixels(10, gap);
      drain(1);
      end_frame();
      chk("rand_outs", pops - p0, 8);
      chk("rand_convs", conv_q.size() - c0, 10);
      if (conv_q.size() - c0 == 10)
        for (int k = 0; k < 10; k++) chk("rand_conv_cycle", conv_q[c0 + k], fall_q[k] + 3);
    end
    chk("rand_overrun", int'(o_overrun), 0);
    chk("rand_short", int'(o_short_frame), 0);

    // latency: one phi_r fall, SAMPLE_DELAY=3 strobes 5 cycles later, 1 gives 3
    do_reset();
    rdy_mode = 0; data_mode = 0; adc_lat = 1;
    start_frame();
    repeat (2) step();
    l0 = lat_q.size(); c0 = conv_q.size();
    t0 = cyc;
    i_phi_r = 1'b0;
    step();
    i_phi_r = 1'b1;
    repeat (12) step();
    chk("lat_sd3_count", lat_q.size() - l0, 1);
    if (lat_q.size() > l0) chk("lat_sd3_cycle", lat_q[l0], t0 + 5);
    chk("lat_sd1_count", conv_q.size() - c0, 1);
    if (conv_q.size() > c0) chk("lat_sd1_cycle", conv_q[c0], t0 + 3);

    // backpressure: 12 active samples against a stalled consumer
    do_reset();
    rdy_mode = 1; data_mode = 0; adc_lat = 1;
    p0 = pops;
    start_frame();
    pixels(10, 4);
    drain(0);
    end_frame();
    start_frame();
    pixels(6, 4);
    drain(0);
    chk("bp_overflow", int'(o_overflow), 1);
    chk("bp_held", pops - p0, 0);
    chk("bp_full_valid", int'(o_pix_valid), 1);
    rdy_mode = 0;
    repeat (20) step();
    chk("bp_drained", pops - p0, 8);
    chk("bp_empty", int'(o_pix_valid), 0);
    pixels(4, 4);
    drain(1);
    end_frame();
    chk("bp_total", pops - p0, 12);
    chk("bp_short", int'(o_short_frame), 0);

    // short frame: phi_p rises after 5 pixels, next fall restarts at idx 0
    do_reset();
    rdy_mode = 0; data_mode = 1; adc_lat = 1;
    p0 = pops;
    start_frame();
    pixels(5, 4);
    drain(1);
    end_frame();
    chk("short_flag", int'(o_short_frame), 1);
    c0 = conv_q.size();
    pixels(2, 4);
    repeat (4) step();
    chk("short_idle_noconv", conv_q.size() - c0, 0);
    start_frame();
    pixels(10, 4);
    drain(1);
    end_frame();
    chk("short_outs", pops - p0, 11);
    chk("short_convs", conv_q.size() - c0, 10);

    // reset mid-frame with 3 entries queued
    do_reset();
    rdy_mode = 1; data_mode = 0; adc_lat = 1;
    start_frame();
    pixels(5, 4);
    repeat (2) step();
    chk("mid_queued", int'(o_pix_valid), 1);
    i_rst_n = 1'b0; i_phi_p = 1'b1;
    step();
    i_rst_n = 1'b1;
    chk("mid_rst_valid", int'(o_pix_valid), 0);
    chk("mid_rst_flags", int'({o_overrun, o_overflow, o_short_frame}), 0);
    c0 = conv_q.size(); p0 = pops;
    rdy_mode = 0;
    pixels(3, 4);
    repeat (4) step();
    chk("mid_no_conv", conv_q.size() - c0, 0);
    start_frame();
    pixels(10, 4);
    drain(1);
    end_frame();
    chk("mid_resume_convs", conv_q.size() - c0, 10);
    chk("mid_resume_outs", pops - p0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
